// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and types for the UART TX arbiter.
// State encoding, default EOL byte, character time and TX write bundle.
package uart_tx_arb_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_OWN  = 1'b1;

  localparam logic [7:0]  EOL_DEF   = 8'h0A;
  // One character time: 50 MHz / 9600 bps.
  localparam logic [15:0] CHAR_TIME = 16'd5208;
  // Ten character times of owner silence.
  localparam logic [15:0] LOCK_TMO_DEF = CHAR_TIME * 16'd10;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_OWN  = ARB_OWN
  } arb_state_t;

  typedef struct packed {
    logic       wten;
    logic [7:0] data;
  } tx_wr_t;

endpackage

// File: rtl/uart_arb_timer.sv
// 16-bit saturating idle counter for the line lock.
// Ports: clk, rst_n, clr (load 0), en (count), hit (limit reached this cycle).
module uart_arb_timer #(
  parameter logic [15:0] LIMIT = 16'd52080
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [15:0] cnt;
  logic [16:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt} + 17'd1;

  // hit marks the cycle whose increment brings the count to LIMIT,
  // so the release edge lands LIMIT cycles after the last clear.
  assign hit = en && !clr
            && (cnt_inc >= {1'b0, LIMIT});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != 16'hFFFF) begin
      cnt <= cnt_inc[15:0];
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter in front of the monitor UART TX FIFO.
// Ports: req0/req1 valid/ready/wdata in, tx_wdata/tx_wten to FIFO,
// tx_fifo_full in, arb_owner/arb_busy status. Macro UART_TX_ARB_LOCK_EN
// selects line locking (EOL or timeout release); else per-byte round-robin.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter logic [7:0]  EOL_CHAR = EOL_DEF,
  parameter logic [15:0] LOCK_TMO = LOCK_TMO_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_wdata,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_wdata,
  output logic       tx_wten,
  input  logic       tx_fifo_full,
  output logic       arb_owner,
  output logic       arb_busy
);

  arb_state_t state, state_nxt;
  logic owner, owner_nxt;
  logic prio, prio_nxt;

  logic       has_gnt;
  logic       gnt;
  logic       gnt_vld;
  logic [7:0] gnt_data;
  logic       acc;
  logic       rel_byte;
  logic       tmo_hit;

  tx_wr_t tx_q;

  always_comb begin
    has_gnt = 1'b0;
    gnt     = owner;
    if (state == ST_OWN) begin
      has_gnt = 1'b1;
    end else begin
      unique case (1'b1)
        req0_valid && req1_valid: begin
          has_gnt = 1'b1;
          gnt     = prio;
        end
        req0_valid && !req1_valid: begin
          has_gnt = 1'b1;
          gnt     = 1'b0;
        end
        !req0_valid && req1_valid: begin
          has_gnt = 1'b1;
          gnt     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt_vld  = gnt ? req1_valid : req0_valid;
  assign gnt_data = gnt ? req1_wdata : req0_wdata;

  // Holding off while a write strobe is out gives the FIFO a cycle
  // to update its full flag before the next accept.
  assign acc = has_gnt && gnt_vld
            && !tx_fifo_full && !tx_q.wten;

  assign req0_ready = acc && !gnt;
  assign req1_ready = acc && gnt;

`ifdef UART_TX_ARB_LOCK_EN
  logic tmr_clr;
  logic tmr_en;

  assign tmr_clr = acc
                || (state == ST_IDLE && has_gnt);
  assign tmr_en  = (state == ST_OWN);

  uart_arb_timer #(
    .LIMIT(LOCK_TMO)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .hit  (tmo_hit)
  );

  assign rel_byte = acc && (gnt_data == EOL_CHAR);
`else
  logic [23:0] unused_cfg;

  assign unused_cfg = {EOL_CHAR, LOCK_TMO};
  assign tmo_hit    = 1'b0;
  // Every accepted byte ends the grant.
  assign rel_byte   = acc;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    unique case (state)
      ST_IDLE: begin
        if (has_gnt) begin
          owner_nxt = gnt;
          if (rel_byte) begin
            prio_nxt = !gnt;
          end else begin
            state_nxt = ST_OWN;
          end
        end
      end
      ST_OWN: begin
        // EOL and timeout are exclusive (timer idles
        // on accept), so priority flips once.
        if (rel_byte || tmo_hit) begin
          state_nxt = ST_IDLE;
          prio_nxt  = !owner;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
      tx_q  <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      prio      <= prio_nxt;
      tx_q.wten <= acc;
      if (acc) begin
        tx_q.data <= gnt_data;
      end
    end
  end

  assign tx_wdata  = tx_q.data;
  assign tx_wten   = tx_q.wten;
  assign arb_owner = owner;
  assign arb_busy  = (state == ST_OWN);

endmodule
